ring_osc_freq_counter: RTL and testbench
========================================

// Module: ring_osc_freq_counter
// PURPOSE
//  Measurement end of the ring oscillator: gates the ring via osc_en (drives ring nrst),
//  divides the free-running osc by 2**DIV_LOG2 in a ripple prescaler, synchronises the
//  divided signal into clk and counts its rising edges over a gate of gate_len clk cycles.
//  Result = ring frequency * gate time / 2**DIV_LOG2; sits between the ring and the TT IO mux.
// PARAMETERS
//  CNT_W       16  width of count result
//  GATE_W      8   width of gate_len (gate window in clk cycles)
//  DIV_LOG2    8   prescaler stages; osc/2**DIV_LOG2 must be < clk/2
//  WARM_CYCLES 4   clk cycles ring is enabled before counting (startup + sync fill)
// PORTS
//  clk       in   1       system clock (scan clock domain)
//  rst       in   1       synchronous reset, active-high
//  start     in   1       request measurement; sampled only in IDLE
//  gate_len  in   GATE_W  gate window length in clk cycles, sampled with start
//  osc       in   1       ring oscillator output (asynchronous to clk)
//  osc_en    out  1       ring enable, wired to ring nrst; 0 stops ring
//  busy      out  1       high in any state except IDLE
//  done      out  1       one-cycle pulse when count/overflow are updated
//  count     out  CNT_W   divided-edge count of last measurement, saturating
//  overflow  out  1       last measurement saturated count
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE, osc_en=0, busy=0, done=0, count=0, overflow=0,
//   internal counter and sync flops cleared. Prescaler flops are unreset (osc domain).
//  Reset mid-measurement aborts: IDLE next cycle, osc_en=0, no done pulse, count keeps 0.
//  FSM: IDLE -> WARMUP -> GATE -> DONE -> IDLE.
//   IDLE:   start=1 -> latch gate_len, clear acc/ovf, go WARMUP; gate_len==0 goes straight
//           to DONE (result count=0, overflow=0). start while busy is ignored.
//   WARMUP: osc_en=1 for exactly WARM_CYCLES cycles, edges NOT counted, then GATE.
//   GATE:   osc_en=1 for exactly gate_len cycles; each detected rising edge increments acc.
//   DONE:   osc_en=0, done=1 for one cycle, count<=acc, overflow<=ovf; next cycle IDLE.
//  Timing: start high at edge k -> WARMUP from k+1, GATE from k+1+WARM_CYCLES,
//   done high at cycle k+1+WARM_CYCLES+gate_len. start held high in DONE is not taken
//   until IDLE (back-to-back min period = WARM_CYCLES+gate_len+2 cycles).
//  Edge detect: div -> s1 -> s2 -> s3 (clk flops); rise = s2 & ~s3. Counted only when
//   state==GATE in that same cycle; edges in sync pipeline at gate end are dropped.
//  Saturation: acc at 2**CNT_W-1 with further rise -> acc holds, ovf=1 (sticky per run).
//  count/overflow change only on done (or rst); hold between measurements.
//  Ring stopped (osc_en=0) -> div static -> no rises; stale div level never makes a rise
//   because s3 tracks s2 during WARMUP.
// STRUCTURE
//  Package ring_osc_pkg: state enum (IDLE,WARMUP,GATE,DONE), WARM_CYCLES default,
//   DIV_LOG2 default shared with ring top-level.
//  Sub-module osc_prescaler: DIV_LOG2 ripple toggle stages, stage0 clocked by osc,
//   output div = last stage; no reset, no clk-domain logic. Everything else single clk.
//  Synchroniser flops s1/s2 marked as async-capture in constraints.
// TESTING (bench models osc as free clock; use DIV_LOG2=2, WARM_CYCLES=4)
//  1 rst held 3 cycles -> all outputs 0; osc_en=0 with osc toggling; no done.
//  2 div rise every 10 clk (osc period 2.5 clk), gate_len=100, start 1 cycle ->
//    done exactly 105 cycles after start edge, count in {9,10,11}, overflow=0.
//  3 gate_len=0, start -> done 1 cycle later, count=0, osc_en never 1.
//  4 CNT_W=4, div rise every 4 clk, gate_len=200 -> count=15, overflow=1; rerun
//    with gate_len=20 -> count in {4,5,6}, overflow=0 (sticky cleared per run).
//  5 start pulsed again during GATE -> ignored, single done; rst asserted mid-GATE
//    -> next cycle busy=0, osc_en=0, no done, count=0.
//  6 osc held static, gate_len=50 -> count=0; start held high continuously ->
//    measurements back-to-back every 56 cycles, done one cycle each.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// Shared types and defaults for the ring oscillator measurement path.
// DIV_LOG2_DEF is also used by the ring top-level.
package ring_osc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_WARMUP = 2'd1;
  localparam state_t S_GATE   = 2'd2;
  localparam state_t S_DONE   = 2'd3;

  localparam int WARM_CYCLES_DEF = 4;
  localparam int DIV_LOG2_DEF    = 8;

endpackage

// File: rtl/ring_osc_freq_counter_if.sv
// Request/result bundle between the scan-side controller
// and the frequency counter.
interface ring_osc_freq_counter_if #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 8
);

  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output start, gate_len,
    input  busy, done, count, overflow
  );

  modport slave (
    input  start, gate_len,
    output busy, done, count, overflow
  );

endinterface

// File: rtl/osc_prescaler.sv
// Ripple divide-by-2**DIV_LOG2 of the free-running ring output.
// Lives entirely in the osc domain and is deliberately unreset.
module osc_prescaler #(
  parameter int DIV_LOG2 = 8
) (
  input  logic osc,
  output logic div
);

  logic [DIV_LOG2-1:0] tap;
  logic                s0_q;

  always_ff @(posedge osc)
    s0_q <= ~s0_q;

  assign tap[0] = s0_q;

  for (genvar i = 1; i < DIV_LOG2; i++) begin : g_stg
    logic q;
    always_ff @(negedge tap[i-1])
      q <= ~q;
    assign tap[i] = q;
  end

  assign div = tap[DIV_LOG2-1];

endmodule

// File: rtl/ring_osc_freq_counter.sv
// Gates the ring, synchronises the divided osc into clk and
// counts its rising edges over a programmable gate window.
module ring_osc_freq_counter
  import ring_osc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 8,
  parameter int DIV_LOG2    = DIV_LOG2_DEF,
  parameter int WARM_CYCLES = WARM_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic osc,
  output logic osc_en,
  ring_osc_freq_counter_if.slave bus
);

  localparam logic [GATE_W-1:0] WARM_LD = GATE_W'(WARM_CYCLES - 1);

  logic div;

  osc_prescaler #(
    .DIV_LOG2(DIV_LOG2)
  ) u_pre (
    .osc(osc),
    .div(div)
  );

  // s1/s2 are the async-capture pair
  logic s1_q, s2_q, s3_q;
  logic rise;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] cnt_q, cnt_d;
  logic [GATE_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovfo_q, ovfo_d;
  logic              osc_en_q, osc_en_d;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    ovfo_d  = ovfo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d = bus.gate_len;
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.gate_len == '0) begin
            state_d = S_DONE;
            count_d = '0;
            ovfo_d  = 1'b0;
          end else begin
            state_d = S_WARMUP;
            cnt_d   = WARM_LD;
          end
        end
      end
      S_WARMUP: begin
        if (cnt_q == '0) begin
          state_d = S_GATE;
          cnt_d   = len_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GATE: begin
        if (rise) begin
          if (acc_q == '1) ovf_d = 1'b1;
          else             acc_d = acc_q + 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
          count_d = acc_d;
          ovfo_d  = ovf_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // registered so the ring nrst never glitches on state decode
    osc_en_d = (state_d == S_WARMUP) || (state_d == S_GATE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      ovfo_q   <= 1'b0;
      osc_en_q <= 1'b0;
    end else begin
      s1_q     <= div;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      ovfo_q   <= ovfo_d;
      osc_en_q <= osc_en_d;
    end
  end

  assign osc_en       = osc_en_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.count    = count_q;
  assign bus.overflow = ovfo_q;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Scoreboard bench: stimulus queues expected results,
// a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_ring_osc_freq_counter;

  localparam int WARM = 4;

  typedef struct {
    int cyc;
    int lo;
    int hi;
    int ov;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    osc = 1'b0;
  logic    osc_en;
  bit      osc_run = 1'b1;
  realtime osc_half = 12.5;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  exp_t    sb[$];
  exp_t    mon_e;

  ring_osc_freq_counter_if #(.CNT_W(4), .GATE_W(8)) bus ();

  ring_osc_freq_counter #(
    .CNT_W(4),
    .GATE_W(8),
    .DIV_LOG2(2),
    .WARM_CYCLES(WARM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .osc(osc),
    .osc_en(osc_en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2.3;
    forever begin
      #(osc_half);
      if (osc_run) osc = ~osc;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act,
                     input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d (cyc %0d)",
               name, act, lo, hi, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done, want none (cyc %0d)",
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.cyc, mon_e.cyc);
        chk("count", int'(bus.count), mon_e.lo, mon_e.hi);
        chk("overflow", int'(bus.overflow), mon_e.ov, mon_e.ov);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure(input int gl, input int lo, input int hi,
                         input int ov, input bit push);
    exp_t e;
    bus.start    = 1'b1;
    bus.gate_len = 8'(gl);
    e.cyc = (gl == 0) ? cyc + 1 : cyc + 1 + WARM + gl;
    e.lo  = lo;
    e.hi  = hi;
    e.ov  = ov;
    if (push) sb.push_back(e);
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!bus.busy) return;
      tick(1);
    end
    chk("idle_timeout", int'(bus.busy), 0, 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.gate_len = '0;

    // reset held with osc running
    tick(3);
    chk("rst_busy", int'(bus.busy), 0, 0);
    chk("rst_done", int'(bus.done), 0, 0);
    chk("rst_count", int'(bus.count), 0, 0);
    chk("rst_ovf", int'(bus.overflow), 0, 0);
    chk("rst_osc_en", int'(osc_en), 0, 0);
    rst = 1'b0;
    tick(2);

    // div rise every 10 clk, gate 100
    measure(100, 9, 11, 0, 1'b1);
    chk("run_osc_en", int'(osc_en), 1, 1);
    chk("run_busy", int'(bus.busy), 1, 1);
    wait_idle(300);
    tick(2);

    // zero-length gate
    measure(0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("gl0_osc_en", int'(osc_en), 0, 0);
      tick(1);
    end
    wait_idle(10);
    tick(2);

    // div rise every 4 clk: saturate, then sticky clears
    osc_half = 5.0;
    measure(200, 15, 15, 1, 1'b1);
    wait_idle(300);
    tick(2);
    measure(20, 4, 6, 0, 1'b1);
    wait_idle(100);
    tick(2);

    // start during GATE ignored
    osc_half = 12.5;
    measure(100, 9, 11, 0, 1'b1);
    tick(50);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_idle(300);
    tick(3);
    chk("restart_busy", int'(bus.busy), 0, 0);

    // rst mid-GATE aborts
    measure(100, 0, 0, 0, 1'b0);
    tick(30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0, 0);
    chk("abort_osc_en", int'(osc_en), 0, 0);
    chk("abort_count", int'(bus.count), 0, 0);
    chk("abort_done", int'(bus.done), 0, 0);
    tick(120);

    // static osc, start held high -> back-to-back runs
    osc_run = 1'b0;
    begin
      int k;
      exp_t e;
      k = cyc;
      bus.start    = 1'b1;
      bus.gate_len = 8'd50;
      for (int i = 0; i < 3; i++) begin
        e.cyc = k + 55 + 56 * i;
        e.lo  = 0;
        e.hi  = 0;
        e.ov  = 0;
        sb.push_back(e);
      end
      for (int i = 0; i < 400 && cyc < k + 167; i++) tick(1);
      bus.start = 1'b0;
    end
    wait_idle(10);
    tick(5);

    chk("sb_drained", sb.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
